lab4_mac_sequencer: RTL and testbench

Downstream consumer of the HPS command PIO in the lab4 accelerator. Takes the 7-bit command word the PIO drives on its `out_port`, detects a start request, and streams N input/weight pairs from dual on-chip memories through a signed multiply-accumulate. It then posts a fixed-point result and busy/done/saturation status for the HPS to read back through an input PIO.

---
 rtl/lab4_mac_sequencer.sv | 77 +++++++
 tb/tb_lab4_mac_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lab4_mac_sequencer.sv
// lab4_mac_sequencer: go-edge triggered N-term signed MAC over dual memories with saturating fixed-point result.
module lab4_mac_sequencer #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        cmd_in,
  output logic [5:0]        mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] w_data,
  output logic [31:0]       result,
  output logic [2:0]        status
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH, DONE} state_t;
  state_t state_q, state_d;
  logic go_q, rd_q, rd_d, rd_d1_q, sat_q, sat_d, start, ovf, last_addr;
  logic [5:0] last_q, last_d, addr_q, addr_d;
  logic [31:0] result_q, result_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, s;
  logic signed [2*DATA_W-1:0] prod;
  assign start = state_q == IDLE && cmd_in[0] && !go_q;
  assign last_addr = addr_q == last_q;
  assign prod = $signed(x_data) * $signed(w_data);
  assign s = acc_q >>> FRAC;
  // s fits in 32 bits only when every bit above bit 31 copies the sign
  assign ovf = s[ACC_W-1:31] != {(ACC_W-31){s[ACC_W-1]}};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      go_q     <= 1'b1;
      rd_q     <= 1'b0;
      rd_d1_q  <= 1'b0;
      sat_q    <= 1'b0;
      last_q   <= '0;
      addr_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= cmd_in[0];
      rd_q     <= rd_d;
      rd_d1_q  <= rd_q;
      sat_q    <= sat_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last_addr ? DRAIN : RUN;
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = DONE;
      DONE:    state_d = cmd_in[0] ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    last_d   = start ? cmd_in[6:1] : last_q;
    rd_d     = start || (state_q == RUN && !last_addr);
    addr_d   = start ? 6'd0 : (state_q == RUN && !last_addr) ? addr_q + 6'd1 : addr_q;
    acc_d    = start ? '0 : rd_d1_q ? acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : acc_q;
    sat_d    = start ? 1'b0 : state_q == FINISH ? ovf : sat_q;
    result_d = state_q != FINISH ? result_q :
               !ovf ? s[31:0] : s[ACC_W-1] ? 32'h8000_0000 : 32'h7fff_ffff;
  end
  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign result   = result_q;
  assign status   = {sat_q, state_q == DONE, state_q inside {RUN, DRAIN, FINISH}};
endmodule

// File: tb/tb_lab4_mac_sequencer.sv
// tb_lab4_mac_sequencer: directed checks of the MAC sequencer, default instance plus a FRAC=0 saturation instance.
module tb_lab4_mac_sequencer;
  logic clk = 1'b0, reset;
  logic [6:0] cmd;
  logic [5:0] addr1, addr2;
  logic rd1, rd2;
  logic [15:0] xd1, wd1, xd2, wd2;
  logic [31:0] res1, res2;
  logic [2:0] st1, st2;
  logic [15:0] xm [64];
  logic [15:0] wm [64];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  lab4_mac_sequencer dut (.clk(clk), .reset(reset), .cmd_in(cmd), .mem_addr(addr1), .mem_rd(rd1),
    .x_data(xd1), .w_data(wd1), .result(res1), .status(st1));
  lab4_mac_sequencer #(.FRAC(0)) dut_f0 (.clk(clk), .reset(reset), .cmd_in(cmd), .mem_addr(addr2), .mem_rd(rd2),
    .x_data(xd2), .w_data(wd2), .result(res2), .status(st2));
  always @(posedge clk) begin
    if (rd1) begin xd1 <= xm[addr1]; wd1 <= wm[addr1]; end
    if (rd2) begin xd2 <= xm[addr2]; wd2 <= wm[addr2]; end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    cmd = 7'h01;
    for (int k = 0; k < 64; k++) begin xm[k] = '0; wm[k] = '0; end
    cyc(2);
    reset = 1'b0;
    chk("rst_result", res1, 0);
    chk("rst_status", {29'd0, st1}, 0);
    chk("rst_rd", {31'd0, rd1}, 0);
    chk("rst_addr", {26'd0, addr1}, 0);
    cyc(3);
    chk("held_go_no_start", {29'd0, st1}, 0);
    chk("held_go_no_rd", {31'd0, rd1}, 0);
    cmd = 7'h00;
    cyc(1);
    xm[0] = 16'h0100; wm[0] = 16'h0200;
    cmd = 7'h01;
    cyc(1);
    chk("n1_rd_e0", {31'd0, rd1}, 1);
    chk("n1_addr_e0", {26'd0, addr1}, 0);
    chk("n1_busy_e0", {29'd0, st1}, 3'b001);
    cyc(1);
    chk("n1_rd_e1", {31'd0, rd1}, 0);
    chk("n1_busy_e1", {29'd0, st1}, 3'b001);
    cyc(1);
    chk("n1_busy_e2", {29'd0, st1}, 3'b001);
    cyc(1);
    chk("n1_status_e3", {29'd0, st1}, 3'b010);
    chk("n1_result_e3", res1, 32'h0000_0200);
    cyc(3);
    chk("done_hold_go", {29'd0, st1}, 3'b010);
    chk("done_hold_no_rd", {31'd0, rd1}, 0);
    cmd = 7'h00;
    cyc(1);
    for (int k = 0; k < 4; k++) begin xm[k] = 16'((k + 1) * 256); wm[k] = 16'h0100; end
    cmd = 7'h07;
    cyc(1);
    chk("n4_addr0", {26'd0, addr1}, 0);
    chk("n4_rd0", {31'd0, rd1}, 1);
    cmd = 7'h06;
    cyc(1);
    chk("n4_addr1", {26'd0, addr1}, 1);
    cmd = 7'h03;
    cyc(1);
    chk("n4_addr2", {26'd0, addr1}, 2);
    cyc(1);
    chk("n4_addr3", {26'd0, addr1}, 3);
    chk("n4_rd3", {31'd0, rd1}, 1);
    cyc(1);
    chk("n4_rd_off_e4", {31'd0, rd1}, 0);
    chk("n4_addr_hold_e4", {26'd0, addr1}, 3);
    chk("n4_busy_e4", {29'd0, st1}, 3'b001);
    cyc(1);
    chk("n4_busy_e5", {29'd0, st1}, 3'b001);
    cyc(1);
    chk("n4_status_e6", {29'd0, st1}, 3'b010);
    chk("n4_result_e6", res1, 32'h0000_0A00);
    cmd = 7'h00;
    cyc(1);
    xm[0] = 16'hFF00; xm[1] = 16'h0100; wm[0] = 16'h0300; wm[1] = 16'h0100;
    cmd = 7'h03;
    cyc(4);
    chk("neg_busy_e3", {29'd0, st1}, 3'b001);
    chk("neg_result_held_e3", res1, 32'h0000_0A00);
    cyc(1);
    chk("neg_status_e4", {29'd0, st1}, 3'b010);
    chk("neg_result_e4", res1, 32'hFFFF_FE00);
    cmd = 7'h00;
    cyc(1);
    for (int k = 0; k < 64; k++) begin xm[k] = 16'h8000; wm[k] = 16'h8000; end
    cmd = 7'h7F;
    cyc(66);
    chk("sat_busy_e65", {29'd0, st2}, 3'b001);
    cyc(1);
    chk("sat_status_e66", {29'd0, st2}, 3'b110);
    chk("sat_result_e66", res2, 32'h7FFF_FFFF);
    chk("nosat_status_e66", {29'd0, st1}, 3'b010);
    chk("nosat_result_e66", res1, 32'h1000_0000);
    cmd = 7'h00;
    cyc(1);
    for (int k = 0; k < 10; k++) begin xm[k] = 16'((k + 1) * 256); wm[k] = 16'h0100; end
    cmd = 7'h13;
    cyc(1);
    chk("r10_addr_e0", {26'd0, addr1}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_rd", {31'd0, rd1}, 0);
    chk("mid_rst_addr", {26'd0, addr1}, 0);
    chk("mid_rst_result", res1, 0);
    chk("mid_rst_status", {29'd0, st1}, 0);
    chk("mid_rst_result_f0", res2, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(15);
    chk("post_rst_no_done", {29'd0, st1}, 0);
    cmd = 7'h00;
    cyc(1);
    cmd = 7'h13;
    cyc(12);
    chk("r10_busy_e11", {29'd0, st1}, 3'b001);
    cyc(1);
    chk("r10_status_e12", {29'd0, st1}, 3'b010);
    chk("r10_result_e12", res1, 32'h0000_3700);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
